// File: rtl/approx_err_monitor_pkg.sv
// rtl/approx_err_monitor_pkg.sv - shared FSM state type and saturating increment for approx_err_monitor
package approx_mon_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLR
  } state_t;

  // Caller narrows the result back to its own width; width must be below 64.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] lim;
    lim = (64'd1 << width) - 64'd1;
    return (val >= lim) ? lim : val + 64'd1;
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// rtl/approx_err_monitor_if.sv - sample stream, clear request and statistics bundle for approx_err_monitor
interface approx_err_monitor_if #(
  parameter int N     = 8,
  parameter int CNT_W = 32,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [N-1:0]     in_sum;
  logic             clear;
  logic             stat_valid;
  logic [CNT_W-1:0] stat_samples;
  logic [CNT_W-1:0] stat_errors;
  logic [ACC_W-1:0] stat_ed_sum;
  logic [N-1:0]     stat_ed_max;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_sum, clear,
    input  in_ready, stat_valid, stat_samples, stat_errors, stat_ed_sum, stat_ed_max, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum, clear,
    output in_ready, stat_valid, stat_samples, stat_errors, stat_ed_sum, stat_ed_max, busy
  );
endinterface

// File: rtl/approx_err_monitor_err_dist_unit.sv
// rtl/approx_err_monitor_err_dist_unit.sv - exact N-bit sum and unsigned distance to the approximate sum
module err_dist_unit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] approx,
  output logic [N-1:0] ed,
  output logic         err
);
  logic [N-1:0] exact;

  // Carry-out is dropped, and the distance is a plain magnitude: no modular folding.
  assign exact = a + b;
  assign ed    = (exact >= approx) ? (exact - approx) : (approx - exact);
  assign err   = (exact != approx);
endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - error-statistics checker for approximate adders
// Optional build macro: APPROX_MON_MAX_EN enables the maximum error-distance tracker.
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 32,
  parameter int ACC_W = 40
) (
  input logic                clk,
  input logic                rst,
  approx_err_monitor_if.slave bus
);
  state_t state, state_nx;
  logic   ready;
  logic   accept;

  logic         s1_valid, s2_valid;
  logic [N-1:0] s1_a, s1_b, s1_sum;
  logic [N-1:0] s2_ed;
  logic         s2_err;
  logic [N-1:0] ed_c;
  logic         err_c;

  logic             stat_valid_q;
  logic [CNT_W-1:0] samples_q, errors_q;
  logic [ACC_W-1:0] ed_sum_q, ed_sum_nx;
  logic [ACC_W:0]   ed_wide;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      RUN: begin
        ready = 1'b1;
        if (bus.clear) state_nx = DRAIN;
      end
      DRAIN: if (!s1_valid && !s2_valid) state_nx = CLR;
      CLR:   state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= bus.in_a;
      s1_b   <= bus.in_b;
      s1_sum <= bus.in_sum;
    end
    if (s1_valid) begin
      s2_ed  <= ed_c;
      s2_err <= err_c;
    end
  end

  err_dist_unit #(.N(N)) u_edu (
    .a      (s1_a),
    .b      (s1_b),
    .approx (s1_sum),
    .ed     (ed_c),
    .err    (err_c)
  );

  always_comb begin
    ed_wide   = {1'b0, ed_sum_q} + {{(ACC_W + 1 - N){1'b0}}, s2_ed};
    ed_sum_nx = ed_wide[ACC_W] ? {ACC_W{1'b1}} : ed_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || state == CLR) begin
      stat_valid_q <= 1'b0;
      samples_q    <= '0;
      errors_q     <= '0;
      ed_sum_q     <= '0;
    end else begin
      stat_valid_q <= s2_valid;
      if (s2_valid) begin
        samples_q <= CNT_W'(sat_inc(64'(samples_q), CNT_W));
        if (s2_err) errors_q <= CNT_W'(sat_inc(64'(errors_q), CNT_W));
        ed_sum_q <= ed_sum_nx;
      end
    end
  end

`ifdef APPROX_MON_MAX_EN
  logic [N-1:0] ed_max_q;
  always_ff @(posedge clk) begin
    if (rst || state == CLR)             ed_max_q <= '0;
    else if (s2_valid && s2_ed > ed_max_q) ed_max_q <= s2_ed;
  end
  assign bus.stat_ed_max = ed_max_q;
`else
  assign bus.stat_ed_max = '0;
`endif

  assign bus.in_ready     = ready;
  assign bus.busy         = s1_valid | s2_valid | (state != RUN);
  assign bus.stat_valid   = stat_valid_q;
  assign bus.stat_samples = samples_q;
  assign bus.stat_errors  = errors_q;
  assign bus.stat_ed_sum  = ed_sum_q;
endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Receiving-side checker for the approximate-adder datapath. Accepts a stream of operand pairs with the sum produced by an approximate adder under test, computes the exact N-bit sum internally, and accumulates error statistics (sample count, erroneous-sample count, summed and maximum error distance). It sits downstream of any `nBitRcpa*` instance and replaces manual waveform inspection of exact versus approximate sums.

## Interface
Parameters:
- `N`, 8, operand and sum width (sum is N bits, carry-out dropped, matching the adders under test)
- `CNT_W`, 32, width of sample and error counters
- `ACC_W`, 40, width of the error-distance accumulator

Ports:
- `clk` input 1: single clock; all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: sample present on `in_a`/`in_b`/`in_sum`
- `in_ready` output 1: block can accept a sample this cycle
- `in_a` input N: operand A
- `in_b` input N: operand B
- `in_sum` input N: approximate sum from the adder under test
- `clear` input 1: request to zero all statistics
- `stat_valid` output 1: one-cycle pulse, statistics just updated
- `stat_samples` output CNT_W: samples accepted since reset/clear
- `stat_errors` output CNT_W: samples with approximate sum ≠ exact sum
- `stat_ed_sum` output ACC_W: sum of error distances
- `stat_ed_max` output N: largest single error distance
- `busy` output 1: pipeline holds in-flight samples or a clear is in progress

## Operation
- Transfer occurs on a rising edge with `in_valid && in_ready`; inputs are don't-care otherwise.
- Exact sum = (`in_a` + `in_b`) mod 2^N. Error distance ED = |exact − `in_sum`|, both operands treated as unsigned N-bit values, result N bits (e.g. exact 0x00, approx 0xFF → ED 0xFF; no modular folding).
- Two-stage pipeline: S1 registers exact sum and approx sum with a valid bit; S2 computes ED and updates the counters.
- Per S2 update: `stat_samples` +1; if ED ≠ 0, `stat_errors` +1; `stat_ed_sum` += ED; `stat_ed_max` = max(`stat_ed_max`, ED).
- All counters and the accumulator saturate at all-ones; they never wrap.
- FSM states:
  - RUN: `in_ready`=1, accept samples.
  - DRAIN: entered from RUN when `clear`=1 is sampled; `in_ready`=0; in-flight samples still accumulate; go to CLR once both pipeline valids are 0.
  - CLR: zero all statistics for one cycle, `in_ready`=0; return to RUN.
- `clear` sampled in DRAIN or CLR is ignored. A sample presented in the same cycle `clear` is first sampled is accepted (`in_ready` was 1) and counted before the zeroing.
- `busy` = S1 valid | S2 valid | state ≠ RUN.

## Timing
- Reset (`rst`=1 at an edge): state RUN, pipeline valids 0, all `stat_*` 0, `stat_valid` 0, `busy` 0, `in_ready` 1 from the following cycle. Reset mid-stream discards in-flight samples with no update.
- Latency: sample accepted at edge t → statistics updated at edge t+2; `stat_valid` high during the cycle after edge t+2.
- Throughput: one sample per cycle in RUN; back-to-back samples give back-to-back `stat_valid` pulses.
- Clear: `clear` sampled at edge t with one sample in S1 → DRAIN, final updates land, CLR, stats 0 and `in_ready`=1 within at most 4 cycles; with an empty pipeline, stats 0 after edge t+2.
- `stat_valid` never asserts in CLR.

## Configuration
- `APPROX_MON_MAX_EN`: when defined, `stat_ed_max` is tracked as described. When undefined, the max register and comparator are not built and `stat_ed_max` is tied to 0; all other behaviour is unchanged.

## Structure
- Package `approx_mon_pkg`: FSM state enum (RUN, DRAIN, CLR) and a saturating-increment helper function.
- Sub-module `err_dist_unit`: combinational exact sum, unsigned absolute difference, and error flag; instantiated in S2.

## Test plan
- Reset, then A=0x30, B=0x05, sum=0x35 → after 2 edges: samples=1, errors=0, ed_sum=0, ed_max=0, one `stat_valid` pulse.
- A=0x47, B=0x70, sum=0xB3 (exact 0xB7) followed by A=0x40, B=0x77, sum=0xBF (exact 0xB7) back-to-back → samples=2, errors=2, ed_sum=12, ed_max=8.
- Wrap case: A=0xFF, B=0x01, sum=0xFF → exact 0x00, ED=255, ed_max=0xFF; repeat with the macro undefined → ed_max stays 0.
- Saturation with CNT_W=3: 9 erroneous samples → samples=7, errors=7, no wrap.
- `clear` asserted alongside a sample: that sample is counted first, `in_ready` drops, then all stats are 0, `in_ready`=1 again, and the next sample gives samples=1.
- `rst` asserted with two samples in flight → no `stat_valid`, all stats 0, `busy`=0.
